// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Command-side initiator for the 16-bit ALU. It accepts one operation on a
// valid/ready command port and drives the ALU operand and function inputs.
// After ALU_LATENCY edges it captures the ALU result and class flags and
// returns them on a valid/ready response port. Only one transaction is
// outstanding at a time, and commands are never queued.
//
// Parameters
//   ALU_LATENCY : edges from the ALU sampling A/B/ALU_FUN to ALU_OUT updating
//                 (legal range 1..15)
//
// Ports
//   CLK, RST          : clock (rising edge), asynchronous active-low reset
//   CMD_VALID/READY   : command handshake
//   CMD_A, CMD_B      : 16-bit operands
//   CMD_FUN           : 4-bit ALU function code
//   A, B, ALU_FUN     : registered drive to the ALU, changed only on accept
//   ALU_OUT           : 32-bit ALU result
//   arith/logic/cmp/shift_flag : ALU class flags
//   RSP_VALID/READY   : response handshake
//   RSP_DATA          : captured ALU_OUT
//   RSP_FLAGS         : captured {arith, logic, cmp, shift} flags
//   RSP_ERR           : captured flags were not exactly one-hot
//
// Optional feature (macro ALU_SEQ_STATS_EN)
//   OP_CNT  : saturating count of response handshakes
//   ERR_CNT : saturating count of response handshakes with RSP_ERR set
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [15:0] CMD_A,
  input  logic [15:0] CMD_B,
  input  logic [3:0]  CMD_FUN,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [3:0]  ALU_FUN,
  input  logic [31:0] ALU_OUT,
  input  logic        arith_flag,
  input  logic        logic_flag,
  input  logic        cmp_flag,
  input  logic        shift_flag,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_DATA,
  output logic [3:0]  RSP_FLAGS,
  output logic        RSP_ERR
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0] OP_CNT,
  output logic [15:0] ERR_CNT
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY);

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic        cmd_ready_c;
  logic        accept;
  logic        capture;
  logic        rsp_done;
  logic [3:0]  flags_in;
  logic        flags_bad;

  assign flags_in = {arith_flag, logic_flag, cmp_flag, shift_flag};
  // Not one-hot: either no flag set, or clearing the lowest set bit leaves one.
  assign flags_bad = (flags_in == 4'd0) || ((flags_in & (flags_in - 4'd1)) != 4'd0);

  // Ready is gated by RST so it reads 0 while reset is held, even though the
  // state register already sits in IDLE.
  assign CMD_READY = cmd_ready_c & RST;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    cmd_ready_c = 1'b0;
    RSP_VALID   = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    rsp_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready_c = 1'b1;
        if (CMD_VALID) begin
          accept     = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) begin
          rsp_done   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Wait counter: loaded with the latency on accept so that the capture edge
  // lands one edge after the ALU output becomes valid.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt <= 4'd0;
    end else if (accept) begin
      wait_cnt <= LAT_LOAD;
    end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // ALU drive registers: change only on command acceptance.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      A       <= 16'd0;
      B       <= 16'd0;
      ALU_FUN <= 4'd0;
    end else if (accept) begin
      A       <= CMD_A;
      B       <= CMD_B;
      ALU_FUN <= CMD_FUN;
    end
  end

  // Response registers: written once per transaction, held through RESP.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RSP_DATA  <= 32'd0;
      RSP_FLAGS <= 4'd0;
      RSP_ERR   <= 1'b0;
    end else if (capture) begin
      RSP_DATA  <= ALU_OUT;
      RSP_FLAGS <= flags_in;
      RSP_ERR   <= flags_bad;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OP_CNT  <= 16'd0;
      ERR_CNT <= 16'd0;
    end else if (rsp_done) begin
      if (OP_CNT != 16'hFFFF) OP_CNT <= OP_CNT + 16'd1;
      if (RSP_ERR && ERR_CNT != 16'hFFFF) ERR_CNT <= ERR_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Self-checking bench for alu_cmd_sequencer. A small behavioural ALU with a
// LAT-deep output pipeline sits on the ALU side; its flags can be overridden
// to provoke one-hot errors. Expected responses come from a transaction-level
// model (function result, class flags, one-hot test, accept-to-valid latency).
// Build with +define+ALU_SEQ_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  localparam int LAT = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [15:0] CMD_A = 16'd0;
  logic [15:0] CMD_B = 16'd0;
  logic [3:0]  CMD_FUN = 4'd0;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  ALU_FUN;
  logic [31:0] ALU_OUT;
  logic        arith_flag, logic_flag, cmp_flag, shift_flag;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [31:0] RSP_DATA;
  logic [3:0]  RSP_FLAGS;
  logic        RSP_ERR;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] OP_CNT;
  logic [15:0] ERR_CNT;
`endif

  alu_cmd_sequencer #(.ALU_LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_FUN(CMD_FUN),
    .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .ALU_OUT(ALU_OUT),
    .arith_flag(arith_flag), .logic_flag(logic_flag),
    .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_DATA(RSP_DATA), .RSP_FLAGS(RSP_FLAGS), .RSP_ERR(RSP_ERR)
`ifdef ALU_SEQ_STATS_EN
    , .OP_CNT(OP_CNT), .ERR_CNT(ERR_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural ALU and reference model ----------------
  function automatic logic [31:0] alu_fn(logic [15:0] a, logic [15:0] b, logic [3:0] fun);
    logic [31:0] ea, eb;
    ea = {16'd0, a};
    eb = {16'd0, b};
    case (fun)
      4'd0:  return ea + eb;
      4'd1:  return ea - eb;
      4'd2:  return ea * eb;
      4'd3:  return {a, b};
      4'd4:  return ea & eb;
      4'd5:  return ea | eb;
      4'd6:  return ea ^ eb;
      4'd7:  return {16'd0, ~(a & b)};
      4'd8:  return (a == b) ? 32'd1 : 32'd0;
      4'd9:  return (a > b)  ? 32'd1 : 32'd0;
      4'd10: return (a < b)  ? 32'd1 : 32'd0;
      4'd11: return (a != b) ? 32'd1 : 32'd0;
      4'd12: return ea << b[3:0];
      4'd13: return ea >> b[3:0];
      4'd14: return {b, a};
      default: return ea << 1;
    endcase
  endfunction

  function automatic logic [3:0] class_flags(logic [3:0] fun);
    case (fun[3:2])
      2'd0:    return 4'b1000;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic flags_err(logic [3:0] f);
    return $countones(f) != 1;
  endfunction

  logic [31:0] d_pipe [LAT];
  logic [3:0]  f_pipe [LAT];
  logic        force_en = 1'b0;
  logic [3:0]  force_val = 4'd0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < LAT; i++) begin
        d_pipe[i] <= 32'd0;
        f_pipe[i] <= 4'd0;
      end
    end else begin
      d_pipe[0] <= alu_fn(A, B, ALU_FUN);
      f_pipe[0] <= class_flags(ALU_FUN);
      for (int i = 1; i < LAT; i++) begin
        d_pipe[i] <= d_pipe[i-1];
        f_pipe[i] <= f_pipe[i-1];
      end
    end
  end

  assign ALU_OUT = d_pipe[LAT-1];
  assign {arith_flag, logic_flag, cmp_flag, shift_flag} = force_en ? force_val : f_pipe[LAT-1];

  // ---------------- checking infrastructure ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int exp_ops = 0;
  int exp_errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a command and return at the negedge after the accept edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
    int n;
    CMD_A = a; CMD_B = b; CMD_FUN = fun; CMD_VALID = 1'b1;
    n = 0;
    while (!CMD_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!CMD_READY) check("cmd_ready_timeout", 32'(CMD_READY), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  // Count edges from acceptance until RSP_VALID is observed.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!RSP_VALID && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
    if (!RSP_VALID) check("rsp_valid_timeout", 32'(RSP_VALID), 32'd1);
  endtask

  // Hold RSP_READY low for 'delay' cycles, then handshake once.
  task automatic finish_rsp(input int delay, input logic exp_err);
    for (int i = 0; i < delay; i++) @(negedge CLK);
    RSP_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RSP_READY = 1'b0;
    if (exp_ops < 16'hFFFF) exp_ops++;
    if (exp_err && exp_errs < 16'hFFFF) exp_errs++;
    check("post_hs_cmd_ready", 32'(CMD_READY), 32'd1);
    check("post_hs_rsp_valid", 32'(RSP_VALID), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] fun, input logic fen, input logic [3:0] fval,
                        input int delay);
    logic [31:0] e_data;
    logic [3:0]  e_flags;
    logic        e_err;
    int          lat;
    e_data  = alu_fn(a, b, fun);
    e_flags = fen ? fval : class_flags(fun);
    e_err   = flags_err(e_flags);
    force_en = fen; force_val = fval;
    issue(a, b, fun);
    check({name, "_drive"}, {A, B}, {a, b});
    check({name, "_fun"}, 32'(ALU_FUN), 32'(fun));
    wait_rsp(lat);
    check({name, "_lat"}, 32'(lat), 32'(LAT + 1));
    check({name, "_data"}, RSP_DATA, e_data);
    check({name, "_flags"}, 32'(RSP_FLAGS), 32'(e_flags));
    check({name, "_err"}, 32'(RSP_ERR), 32'(e_err));
    finish_rsp(delay, e_err);
    force_en = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
    logic        fen;
    logic [3:0]  fval;
    logic [31:0] exp_data;
    logic [3:0]  exp_flags;
    logic        exp_err;
  } vec_t;

  vec_t tbl [10];

  initial begin : main
    int lat;
    logic [31:0] held_data;
    logic [3:0]  held_flags;

    tbl[0] = '{16'h0003, 16'h0004, 4'd0,  1'b0, 4'h0, 32'h0000_0007, 4'b1000, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 4'd0,  1'b0, 4'h0, 32'h0001_0000, 4'b1000, 1'b0};
    tbl[2] = '{16'h00F0, 16'h0FF0, 4'd4,  1'b0, 4'h0, 32'h0000_00F0, 4'b0100, 1'b0};
    tbl[3] = '{16'h0005, 16'h0005, 4'd8,  1'b0, 4'h0, 32'h0000_0001, 4'b0010, 1'b0};
    tbl[4] = '{16'h0001, 16'h0004, 4'd12, 1'b0, 4'h0, 32'h0000_0010, 4'b0001, 1'b0};
    tbl[5] = '{16'h0003, 16'h0004, 4'd0,  1'b1, 4'h0, 32'h0000_0007, 4'b0000, 1'b1};
    tbl[6] = '{16'h1234, 16'h5678, 4'd6,  1'b1, 4'hC, 32'h0000_444C, 4'b1100, 1'b1};
    tbl[7] = '{16'h0002, 16'h0003, 4'd2,  1'b0, 4'h0, 32'h0000_0006, 4'b1000, 1'b0};
    tbl[8] = '{16'h0000, 16'h0001, 4'd1,  1'b0, 4'h0, 32'hFFFF_FFFF, 4'b1000, 1'b0};
    tbl[9] = '{16'h0003, 16'h0002, 4'd9,  1'b1, 4'hF, 32'h0000_0001, 4'b1111, 1'b1};

    // Reset values while RST is held low, then ready after release.
    repeat (2) @(negedge CLK);
    check("rst_cmd_ready", 32'(CMD_READY), 32'd0);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_drive", {A, B}, 32'd0);
    check("rst_rsp", {RSP_DATA[27:0], RSP_FLAGS}, 32'd0);
    check("rst_err_fun", {27'd0, RSP_ERR, ALU_FUN}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("idle_cmd_ready", 32'(CMD_READY), 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      force_en = tbl[i].fen; force_val = tbl[i].fval;
      issue(tbl[i].a, tbl[i].b, tbl[i].fun);
      check($sformatf("tbl%0d_a", i), 32'(A), 32'(tbl[i].a));
      wait_rsp(lat);
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(LAT + 1));
      check($sformatf("tbl%0d_data", i), RSP_DATA, tbl[i].exp_data);
      check($sformatf("tbl%0d_flags", i), 32'(RSP_FLAGS), 32'(tbl[i].exp_flags));
      check($sformatf("tbl%0d_err", i), 32'(RSP_ERR), 32'(tbl[i].exp_err));
      finish_rsp(i % 3, tbl[i].exp_err);
      force_en = 1'b0;
    end

    // Back-pressure: response and flags held while the ALU-side flags change.
    issue(16'h0010, 16'h0020, 4'd5);
    wait_rsp(lat);
    held_data = RSP_DATA; held_flags = RSP_FLAGS;
    check("bp_data", held_data, 32'h0000_0030);
    force_en = 1'b1; force_val = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("bp_valid", 32'(RSP_VALID), 32'd1);
      check("bp_hold", {RSP_DATA[27:0], RSP_FLAGS}, {held_data[27:0], held_flags});
      check("bp_cmd_ready", 32'(CMD_READY), 32'd0);
    end
    force_en = 1'b0;
    finish_rsp(0, 1'b0);

    // Command presented during WAIT is ignored, then taken once back in IDLE.
    issue(16'h0100, 16'h0001, 4'd0);
    CMD_A = 16'hFFFF; CMD_B = 16'h0000; CMD_FUN = 4'd0; CMD_VALID = 1'b1;
    wait_rsp(lat);
    check("ign_lat", 32'(lat), 32'(LAT + 1));
    check("ign_a_held", 32'(A), 32'h0100);
    check("ign_cmd_ready", 32'(CMD_READY), 32'd0);
    check("ign_data", RSP_DATA, 32'h0000_0101);
    RSP_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RSP_READY = 1'b0;
    if (exp_ops < 16'hFFFF) exp_ops++;
    check("ign_idle_ready", 32'(CMD_READY), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    check("ign_late_accept", 32'(A), 32'hFFFF);
    check("ign_busy", 32'(CMD_READY), 32'd0);
    wait_rsp(lat);
    check("ign2_lat", 32'(lat), 32'(LAT + 1));
    check("ign2_data", RSP_DATA, 32'h0000_FFFF);
    finish_rsp(0, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic [3:0]  rf, rv;
      logic        fe;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rf = 4'($urandom_range(0, 15));
      fe = ($urandom_range(0, 3) == 0);
      rv = 4'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d", i), ra, rb, rf, fe, rv, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) @(negedge CLK);
    end

    // Reset mid-transaction: state dropped immediately, no response later.
    issue(16'h0042, 16'h0001, 4'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("mid_rst_valid", 32'(RSP_VALID), 32'd0);
    check("mid_rst_drive", {A, B}, 32'd0);
    check("mid_rst_fun", 32'(ALU_FUN), 32'd0);
    check("mid_rst_ready", 32'(CMD_READY), 32'd0);
    exp_ops = 0; exp_errs = 0;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("post_rst_no_rsp", {31'd0, RSP_VALID}, 32'd0);
    end
    check("post_rst_ready", 32'(CMD_READY), 32'd1);

    // Five operations after reset, two with corrupted flags.
    run_op("st0", 16'h0001, 16'h0001, 4'd0, 1'b0, 4'h0, 0);
    run_op("st1", 16'h0002, 16'h0002, 4'd5, 1'b1, 4'h0, 1);
    run_op("st2", 16'h0003, 16'h0001, 4'd10, 1'b0, 4'h0, 0);
    run_op("st3", 16'h0004, 16'h0001, 4'd13, 1'b1, 4'h6, 2);
    run_op("st4", 16'h0005, 16'h0002, 4'd1, 1'b0, 4'h0, 0);
`ifdef ALU_SEQ_STATS_EN
    check("op_cnt", 32'(OP_CNT), 32'(exp_ops));
    check("err_cnt", 32'(ERR_CNT), 32'(exp_errs));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
